// File: rtl/downcounter_pkg.sv
// downcounter_pkg: shared types, widths and the prediction function for the even down counter
package downcounter_pkg;
  localparam int CNT_W = 8;
  localparam int DEF_STEP = 2;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  function automatic logic [CNT_W-1:0] next_even_down(input logic [CNT_W-1:0] value, input logic [CNT_W-1:0] step);
    return value - step;
  endfunction
endpackage

// File: rtl/even_down_checker.sv
// even_down_checker: checks an even down-counter stream for parity and step errors, tracks lock
module even_down_checker
  import downcounter_pkg::*;
#(
  parameter int STEP = DEF_STEP,
  parameter int LOCK_N = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             odd_err,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] expected
);
  state_t           r_state, w_state_nxt;
  logic [3:0]       r_match, w_match_nxt;
  logic [CNT_W-1:0] r_expected;
  logic [ERR_W-1:0] r_err_count, w_err_base, w_err_nxt;
  logic             r_locked, r_odd, r_seq;
  logic             w_odd, w_seq, w_err;
  assign w_odd = cnt_in[0];
  assign w_seq = (r_state != IDLE) && (cnt_in != r_expected);
  assign w_err = w_odd | w_seq;
  // the clear takes effect before this cycle's increment
  assign w_err_base = clr_err ? '0 : r_err_count;
  assign w_err_nxt = (cnt_valid && w_err && !(&w_err_base)) ? w_err_base + ERR_W'(1) : w_err_base;
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    if (cnt_valid) begin
      if (r_state == IDLE || w_err) begin
        w_state_nxt = ACQUIRE;
        w_match_nxt = '0;
      end else if (r_state == ACQUIRE) begin
        w_match_nxt = r_match + 4'd1;
        if (w_match_nxt == 4'(LOCK_N)) begin
          w_state_nxt = LOCKED;
          w_match_nxt = '0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_match     <= '0;
      r_expected  <= '0;
      r_err_count <= '0;
      r_locked    <= 1'b0;
      r_odd       <= 1'b0;
      r_seq       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match     <= w_match_nxt;
      r_err_count <= w_err_nxt;
      r_locked    <= (w_state_nxt == LOCKED);
      r_odd       <= cnt_valid & w_odd;
      r_seq       <= cnt_valid & w_seq;
      if (cnt_valid) r_expected <= next_even_down(cnt_in, CNT_W'(STEP));
    end
  end
  assign locked    = r_locked;
  assign odd_err   = r_odd;
  assign seq_err   = r_seq;
  assign err_count = r_err_count;
  assign expected  = r_expected;
endmodule

// File: tb/tb_even_down_checker.sv
// tb_even_down_checker: directed stimulus against a behavioural stream model, plus literal checks
module tb_even_down_checker;
  import downcounter_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  cnt_in = '0;
  logic        cnt_valid = 1'b0;
  logic        clr_err = 1'b0;
  logic        locked, odd_err, seq_err, s_locked, s_odd, s_seq;
  logic [15:0] err_count;
  logic [1:0]  s_err_count;
  logic [7:0]  expected, s_expected;
  int n_chk = 0, n_fail = 0;
  logic       m_have = 0, m_locked = 0, m_odd = 0, m_seq = 0;
  int         m_run = 0, m_c16 = 0, m_c2 = 0;
  logic [7:0] m_exp = '0;
  even_down_checker #(.STEP(2), .LOCK_N(4), .ERR_W(16)) u_dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_err(clr_err),
    .locked(locked), .odd_err(odd_err), .seq_err(seq_err), .err_count(err_count), .expected(expected)
  );
  even_down_checker #(.STEP(2), .LOCK_N(4), .ERR_W(2)) u_small (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_err(clr_err),
    .locked(s_locked), .odd_err(s_odd), .seq_err(s_seq), .err_count(s_err_count), .expected(s_expected)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
    end
  endtask
  task automatic model_reset();
    m_have = 0; m_locked = 0; m_odd = 0; m_seq = 0; m_run = 0; m_c16 = 0; m_c2 = 0; m_exp = '0;
  endtask
  always @(negedge clk) begin
    chk("locked", 32'(locked), 32'(m_locked));
    chk("odd_err", 32'(odd_err), 32'(m_odd));
    chk("seq_err", 32'(seq_err), 32'(m_seq));
    chk("expected", 32'(expected), 32'(m_exp));
    chk("err_count", 32'(err_count), 32'(m_c16));
    chk("err_count_w2", 32'(s_err_count), 32'(m_c2));
  end
  task automatic cyc(input logic v, input logic [7:0] d, input logic c);
    logic odd, seq, err, have, lk;
    int run, c16, c2;
    logic [7:0] ex;
    cnt_valid = v; cnt_in = d; clr_err = c;
    odd = v & d[0];
    seq = v && m_have && (d != m_exp);
    err = odd | seq;
    have = m_have | v; lk = m_locked; run = m_run; ex = m_exp;
    c16 = c ? 0 : m_c16;
    c2 = c ? 0 : m_c2;
    if (v) begin
      ex = next_even_down(d, 8'd2);
      if (!m_have || err) begin run = 0; lk = 0; end
      else if (!m_locked) begin run++; lk = (run == 4); end
      if (err && c16 < 65535) c16++;
      if (err && c2 < 3) c2++;
    end
    @(posedge clk);
    #1;
    m_have = have; m_locked = lk; m_run = run; m_exp = ex; m_odd = odd; m_seq = seq; m_c16 = c16; m_c2 = c2;
    @(negedge clk);
  endtask
  task automatic samples(input int n, input logic [7:0] first);
    logic [7:0] v = first;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, v, 1'b0);
      v = v - 8'd2;
    end
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_expected", 32'(expected), 0);
    chk("rst_err", 32'(err_count), 0);
    #2 rst = 1'b1;
    samples(4, 8'd20);
    chk("t1_not_locked", 32'(locked), 0);
    cyc(1'b1, 8'd12, 1'b0);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_expected", 32'(expected), 10);
    chk("t1_err", 32'(err_count), 0);
    samples(2, 8'd10);
    cyc(1'b1, 8'd5, 1'b0);
    chk("t3_odd", 32'(odd_err), 1);
    chk("t3_seq", 32'(seq_err), 1);
    chk("t3_err", 32'(err_count), 1);
    chk("t3_unlocked", 32'(locked), 0);
    chk("t3_expected", 32'(expected), 3);
    samples(2, 8'd3);
    chk("t3_err3", 32'(err_count), 3);
    chk("t3_seq_clean", 32'(seq_err), 0);
    samples(5, 8'd14);
    chk("t2_pre_locked", 32'(locked), 1);
    samples(5, 8'd4);
    chk("t2_wrap_locked", 32'(locked), 1);
    chk("t2_wrap_expected", 32'(expected), 250);
    chk("t2_err", 32'(err_count), 4);
    cyc(1'b1, 8'd30, 1'b0);
    repeat (3) cyc(1'b0, 8'd99, 1'b0);
    chk("t4_gap_hold", 32'(expected), 28);
    samples(4, 8'd28);
    chk("t4_locked", 32'(locked), 1);
    chk("t4_err", 32'(err_count), 5);
    cyc(1'b0, 8'd0, 1'b1);
    chk("t5_clr", 32'(s_err_count), 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(21 - 2 * i), 1'b0);
    chk("t5_sat", 32'(s_err_count), 3);
    chk("t5_wide", 32'(err_count), 5);
    cyc(1'b1, 8'd11, 1'b1);
    chk("t5_clr_inc", 32'(s_err_count), 1);
    chk("t5_clr_inc_wide", 32'(err_count), 1);
    cyc(1'b0, 8'd0, 1'b1);
    chk("t5_clr_alone", 32'(err_count), 0);
    repeat (3) cyc(1'b1, 8'd40, 1'b0);
    chk("const_seq", 32'(seq_err), 1);
    samples(5, 8'd38);
    chk("t6_locked", 32'(locked), 1);
    cnt_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("t6_async_locked", 32'(locked), 0);
    chk("t6_async_expected", 32'(expected), 0);
    chk("t6_async_err", 32'(err_count), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    cyc(1'b1, 8'd100, 1'b0);
    chk("t6_first_seq", 32'(seq_err), 0);
    chk("t6_first_expected", 32'(expected), 98);
    samples(4, 8'd98);
    chk("t6_relock", 32'(locked), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/even_down_checker.md
Name: even_down_checker

Overview:
- Receive-side monitor for the 8-bit even down counter. It samples the counter output and checks that each sample is even and exactly STEP below the previous one, with wrap from 0 to 254.
- Reports lock status, per-sample error pulses and a saturating error count.
- Sits beside the counter in the subsystem and in the bench as a self-checking consumer.

Parameters:
- STEP, 2: expected decrement between consecutive valid samples; must be even and nonzero.
- LOCK_N, 4: number of consecutive correct transitions required to enter LOCKED; range 1..15.
- ERR_W, 16: width of the error counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cnt_in  input  8  counter value under check.
- cnt_valid  input  1  cnt_in is a sample this cycle; samples are ignored when low.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- odd_err  output  1  one-cycle pulse: the last valid sample had bit0 = 1.
- seq_err  output  1  one-cycle pulse: the last valid sample did not equal expected.
- err_count  output  ERR_W  number of erroneous samples; saturates at all-ones.
- expected  output  8  predicted next sample value.

Behaviour:
- Reset (rst = 0, asynchronous): state = IDLE, locked = 0, odd_err = 0, seq_err = 0, err_count = 0, expected = 0, internal match counter = 0.
- All outputs are registered. The response to the sample taken at edge N is visible after edge N.
- Prediction: expected <= (cnt_in - STEP) mod 256, computed in 8-bit arithmetic. With STEP = 2: 0 -> 254, 2 -> 0.
  - expected updates on every valid sample, including erroneous ones, so the checker resynchronises to the observed value.
- Error classification for a valid sample:
  - odd_err = cnt_in[0].
  - seq_err = (state != IDLE) && (cnt_in != expected).
  - Both pulses may assert together.
  - A sample counts as erroneous if odd_err or seq_err is set; it adds exactly 1 to err_count even when both are set.
- States and transitions:
  - IDLE: first valid sample -> ACQUIRE, match counter = 0. No seq_err is possible here, but odd_err is still flagged.
  - ACQUIRE:
    - Correct sample: match counter increments.
    - Match counter reaches LOCK_N: go to LOCKED, locked = 1 on that same edge.
    - Erroneous sample: match counter = 0, stay in ACQUIRE.
  - LOCKED:
    - Correct sample: stay in LOCKED.
    - Erroneous sample: go to ACQUIRE, locked = 0, match counter = 0.
- cnt_valid = 0: state, expected and err_count hold; odd_err and seq_err are 0. Gaps are not errors.
- err_count:
  - Saturates at 2^ERR_W - 1 and never wraps.
  - clr_err alone -> 0.
  - clr_err in the same cycle as an erroneous sample -> 1 (the clear applies first, then the increment).
- Mid-operation reset: immediate return to IDLE. The first sample after reset release is never flagged as seq_err.
- A constant value with valid held high is a seq_err on every sample after the first.

Decomposition:
- Add to downcounter_pkg:
  - state typedef enum {IDLE, ACQUIRE, LOCKED}.
  - CNT_W = 8 and the default STEP constant.
  - A function next_even_down(value, step) returning the predicted value. The same function is used by the RTL and the bench model.
- No sub-module. The predictor is a single subtraction; the FSM, match counter and error counter fit in one module.

Test Plan:
- Reset then a clean sequence 20, 18, 16, 14, 12 with valid high -> locked rises after the 5th sample (LOCK_N = 4), err_count = 0, expected = 10.
- Wrap: locked, then samples 4, 2, 0, 254, 252 -> no seq_err, locked stays 1, expected = 250.
- Fault while locked: sequence ...10, 8, then 5 -> odd_err = 1 and seq_err = 1 on the same cycle, err_count = 1, locked = 0, expected = 3. Next 3, 1 -> two odd_err pulses, err_count = 3.
- Gaps: 30, then valid low for 3 cycles, then 28, 26, 24, 22 -> no errors; locked after the 22 sample.
- Counter limits: ERR_W = 2 with 5 consecutive odd samples -> err_count stops at 3. Then clr_err together with an odd sample -> err_count = 1; clr_err alone -> 0.
- Reset mid-run: rst low while locked -> all outputs 0 asynchronously. After release, first sample 100 -> no seq_err, state = ACQUIRE.
